// File: rtl/arb_req_queue_if.sv
// Handshake bundle between the burst-command source / arbiter and the
// two-channel request queue.
//   slave  : queue side (takes push/len/gnt, drives req/full/done/err)
//   master : source/arbiter side
interface arb_req_queue_if #(
  parameter int LEN_W = 4
);
  logic             push1;
  logic [LEN_W-1:0] len1;
  logic             push2;
  logic [LEN_W-1:0] len2;
  logic             gnt1;
  logic             gnt2;
  logic             req1;
  logic             req2;
  logic             full1;
  logic             full2;
  logic             done1;
  logic             done2;
  logic             err1;
  logic             err2;

  modport slave (
    input  push1, len1, push2, len2, gnt1, gnt2,
    output req1, req2, full1, full2, done1, done2, err1, err2
  );

  modport master (
    output push1, len1, push2, len2, gnt1, gnt2,
    input  req1, req2, full1, full2, done1, done2, err1, err2
  );
endinterface

// File: rtl/arb_req_queue.sv
// Upstream request stage for a two-requester arbiter.
// Each channel queues burst commands (beat count) in a DEPTH-entry FIFO,
// holds its request line while the FIFO is non-empty, counts grant beats
// against the head burst, pulses done after the last beat and latches
// protocol errors (push when full, zero length, grant without request).
// Ports:
//   clk  - clock, all state on rising edge
//   rst  - asynchronous active-high reset
//   bus  - slave side of arb_req_queue_if (push/len/gnt in,
//          req/full/done/err out, per channel 1 and 2)
module arb_req_queue #(
  parameter int DEPTH = 4,
  parameter int LEN_W = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  arb_req_queue_if.slave       bus
);

  localparam int AW = $clog2(DEPTH);

  logic [1:0]       w_push;
  logic [1:0]       w_gnt;
  logic [LEN_W-1:0] w_len [2];
  logic [1:0]       w_req;
  logic [1:0]       w_full;
  logic [1:0]       w_done;
  logic [1:0]       w_err;

  assign w_push   = {bus.push2, bus.push1};
  assign w_gnt    = {bus.gnt2, bus.gnt1};
  assign w_len[0] = bus.len1;
  assign w_len[1] = bus.len2;

  for (genvar ch = 0; ch < 2; ch++) begin : g_ch
    logic [LEN_W-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr;
    logic [AW-1:0]    r_rd;
    logic [AW:0]      r_count;
    logic [LEN_W-1:0] r_served;
    logic             r_done;
    logic             r_err;

    logic             w_len_zero;
    logic             w_push_ok;
    logic             w_beat;
    logic             w_pop;
    logic [LEN_W-1:0] w_served_inc;

    // Request and full come straight from registered count so the
    // arbiter's combinational grant logic never sees an input-to-req path.
    assign w_req[ch]    = (r_count != '0);
    assign w_full[ch]   = (r_count == (AW+1)'(DEPTH));
    assign w_len_zero   = (w_len[ch] == '0);
    // Full is checked on the registered value: a same-cycle pop does not
    // make room for a push.
    assign w_push_ok    = w_push[ch] & ~w_len_zero & ~w_full[ch];
    assign w_beat       = w_gnt[ch] & w_req[ch];
    assign w_served_inc = r_served + 1'b1;
    assign w_pop        = w_beat & (w_served_inc == r_mem[r_rd]);

    always_ff @(posedge clk) begin
      if (w_push_ok) begin
        r_mem[r_wr] <= w_len[ch];
      end
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        r_wr     <= '0;
        r_rd     <= '0;
        r_count  <= '0;
        r_served <= '0;
        r_done   <= 1'b0;
        r_err    <= 1'b0;
      end else begin
        if (w_push_ok) begin
          r_wr <= r_wr + 1'b1;
        end
        if (w_pop) begin
          r_rd <= r_rd + 1'b1;
        end
        case ({w_push_ok, w_pop})
          2'b10:   r_count <= r_count + 1'b1;
          2'b01:   r_count <= r_count - 1'b1;
          default: r_count <= r_count;
        endcase
        if (w_pop) begin
          r_served <= '0;
        end else if (w_beat) begin
          r_served <= w_served_inc;
        end
        r_done <= w_pop;
        if ((w_push[ch] & (w_full[ch] | w_len_zero)) | (w_gnt[ch] & ~w_req[ch])) begin
          r_err <= 1'b1;
        end
      end
    end

    assign w_done[ch] = r_done;
    assign w_err[ch]  = r_err;
  end

  assign bus.req1  = w_req[0];
  assign bus.req2  = w_req[1];
  assign bus.full1 = w_full[0];
  assign bus.full2 = w_full[1];
  assign bus.done1 = w_done[0];
  assign bus.done2 = w_done[1];
  assign bus.err1  = w_err[0];
  assign bus.err2  = w_err[1];

endmodule

// File: tb/tb_arb_req_queue.sv
module tb_arb_req_queue;
  localparam int DEPTH = 4;
  localparam int LEN_W = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  arb_req_queue_if #(.LEN_W(LEN_W)) bus ();

  arb_req_queue #(.DEPTH(DEPTH), .LEN_W(LEN_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Observed/expected vector: {req1,req2,full1,full2,done1,done2,err1,err2}
  typedef struct {
    logic       p1;
    logic [3:0] l1;
    logic       g1;
    logic       p2;
    logic [3:0] l2;
    logic       g2;
    logic [7:0] exp;
  } vec_t;

  localparam int NVEC = 18;
  vec_t vt [NVEC];

  int n_vec  = 0;
  int n_miss = 0;
  int q1[$];
  int q2[$];
  int beats1 = 0;
  int beats2 = 0;
  int dones1 = 0;
  int dones2 = 0;

  function automatic logic [7:0] obs_now();
    return {bus.req1, bus.req2, bus.full1, bus.full2,
            bus.done1, bus.done2, bus.err1, bus.err2};
  endfunction

  task automatic check8(input string name, input logic [7:0] act,
                        input logic [7:0] exp, input logic [7:0] mask);
    n_vec++;
    if (((act ^ exp) & mask) !== 8'h00) begin
      n_miss++;
      $display("FAIL %s: got %b want %b (mask %b) at %0t", name, act, exp, mask, $time);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_miss++;
      $display("FAIL %s: got %0d want %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic sb_clear();
    q1.delete();
    q2.delete();
    beats1 = 0;
    beats2 = 0;
  endtask

  task automatic drive_idle();
    bus.push1 = 1'b0; bus.len1 = '0; bus.gnt1 = 1'b0;
    bus.push2 = 1'b0; bus.len2 = '0; bus.gnt2 = 1'b0;
  endtask

  // Apply one cycle of inputs, let the edge happen, compare outputs.
  // Scoreboard: accepted pushes queue their length; granted beats are
  // counted while a burst is outstanding; each done pulse pops the head
  // and must match the number of beats granted to it.
  task automatic step(input logic p1, input logic [3:0] l1, input logic g1,
                      input logic p2, input logic [3:0] l2, input logic g2,
                      input logic [7:0] exp, input logic [7:0] mask,
                      input string name, output logic [7:0] obs);
    bus.push1 = p1; bus.len1 = l1; bus.gnt1 = g1;
    bus.push2 = p2; bus.len2 = l2; bus.gnt2 = g2;
    if (g1 && q1.size() != 0) beats1++;
    if (g2 && q2.size() != 0) beats2++;
    if (p1 && l1 != 0 && q1.size() < DEPTH) q1.push_back(int'(l1));
    if (p2 && l2 != 0 && q2.size() < DEPTH) q2.push_back(int'(l2));
    @(posedge clk);
    #1;
    obs = obs_now();
    check8(name, obs, exp, mask);
    if (obs[3] === 1'b1) begin
      dones1++;
      if (q1.size() == 0) begin
        n_vec++; n_miss++;
        $display("FAIL sb_done1: got unexpected done1 want none at %0t", $time);
      end else begin
        check_int("sb_len1", beats1, q1[0]);
        void'(q1.pop_front());
        beats1 = 0;
      end
    end
    if (obs[2] === 1'b1) begin
      dones2++;
      if (q2.size() == 0) begin
        n_vec++; n_miss++;
        $display("FAIL sb_done2: got unexpected done2 want none at %0t", $time);
      end else begin
        check_int("sb_len2", beats2, q2[0]);
        void'(q2.pop_front());
        beats2 = 0;
      end
    end
  endtask

  task automatic do_reset();
    drive_idle();
    rst = 1'b1;
    #1;
    check8("rst_async", obs_now(), 8'h00, 8'hFF);
    @(posedge clk);
    #1;
    check8("rst_hold", obs_now(), 8'h00, 8'hFF);
    rst = 1'b0;
    sb_clear();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] o;
    logic       g1;
    logic       g2;
    int         last;
    int         d1;
    int         d2;

    // len3 burst, granted every cycle
    vt[0]  = '{1'b1, 4'd3, 1'b0, 1'b0, 4'd0, 1'b0, 8'b1000_0000};
    vt[1]  = '{1'b0, 4'd0, 1'b1, 1'b0, 4'd0, 1'b0, 8'b1000_0000};
    vt[2]  = '{1'b0, 4'd0, 1'b1, 1'b0, 4'd0, 1'b0, 8'b1000_0000};
    vt[3]  = '{1'b0, 4'd0, 1'b1, 1'b0, 4'd0, 1'b0, 8'b0000_1000};
    vt[4]  = '{1'b0, 4'd0, 1'b0, 1'b0, 4'd0, 1'b0, 8'b0000_0000};
    // channel 2 length-1 burst pops in one granted cycle
    vt[5]  = '{1'b0, 4'd0, 1'b0, 1'b1, 4'd1, 1'b0, 8'b0100_0000};
    vt[6]  = '{1'b0, 4'd0, 1'b0, 1'b0, 4'd0, 1'b1, 8'b0000_0100};
    vt[7]  = '{1'b0, 4'd0, 1'b0, 1'b0, 4'd0, 1'b0, 8'b0000_0000};
    // fill channel 1, overflow push, then drain
    vt[8]  = '{1'b1, 4'd1, 1'b0, 1'b0, 4'd0, 1'b0, 8'b1000_0000};
    vt[9]  = '{1'b1, 4'd1, 1'b0, 1'b0, 4'd0, 1'b0, 8'b1000_0000};
    vt[10] = '{1'b1, 4'd1, 1'b0, 1'b0, 4'd0, 1'b0, 8'b1000_0000};
    vt[11] = '{1'b1, 4'd1, 1'b0, 1'b0, 4'd0, 1'b0, 8'b1010_0000};
    vt[12] = '{1'b1, 4'd1, 1'b0, 1'b0, 4'd0, 1'b0, 8'b1010_0010};
    vt[13] = '{1'b0, 4'd0, 1'b1, 1'b0, 4'd0, 1'b0, 8'b1000_1010};
    vt[14] = '{1'b0, 4'd0, 1'b1, 1'b0, 4'd0, 1'b0, 8'b1000_1010};
    vt[15] = '{1'b0, 4'd0, 1'b1, 1'b0, 4'd0, 1'b0, 8'b1000_1010};
    vt[16] = '{1'b0, 4'd0, 1'b1, 1'b0, 4'd0, 1'b0, 8'b0000_1010};
    vt[17] = '{1'b0, 4'd0, 1'b0, 1'b0, 4'd0, 1'b0, 8'b0000_0010};

    drive_idle();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check8("reset_state", obs_now(), 8'h00, 8'hFF);
    rst = 1'b0;
    sb_clear();

    for (int i = 0; i < NVEC; i++) begin
      step(vt[i].p1, vt[i].l1, vt[i].g1, vt[i].p2, vt[i].l2, vt[i].g2,
           vt[i].exp, 8'hFF, $sformatf("vec%0d", i), o);
    end

    // Both channels len2 behind a round-robin arbiter
    do_reset();
    d1 = dones1;
    d2 = dones2;
    step(1'b1, 4'd2, 1'b0, 1'b1, 4'd2, 1'b0, 8'b1100_0000, 8'hFF, "c_push", o);
    last = 2;
    for (int cyc = 0; cyc < 12 && (q1.size() != 0 || q2.size() != 0); cyc++) begin
      g1 = bus.req1 && (!bus.req2 || last == 2);
      g2 = bus.req2 && !g1;
      if (g1) last = 1;
      else if (g2) last = 2;
      step(1'b0, 4'd0, g1, 1'b0, 4'd0, g2, 8'h00, 8'h03, "c_arb", o);
    end
    check_int("c_drain", q1.size() + q2.size(), 0);
    check_int("c_done1", dones1 - d1, 1);
    check_int("c_done2", dones2 - d2, 1);

    // Zero-length push and spurious grant on channel 2
    step(1'b0, 4'd0, 1'b0, 1'b1, 4'd0, 1'b0, 8'b0000_0001, 8'hFF, "d_len0", o);
    step(1'b0, 4'd0, 1'b0, 1'b0, 4'd0, 1'b1, 8'b0000_0001, 8'hFF, "d_spur", o);
    step(1'b0, 4'd0, 1'b0, 1'b0, 4'd0, 1'b0, 8'b0000_0001, 8'hFF, "d_idle", o);

    // Reset in the middle of a partially served len5 burst
    do_reset();
    step(1'b1, 4'd5, 1'b0, 1'b0, 4'd0, 1'b0, 8'b1000_0000, 8'hFF, "e_push", o);
    step(1'b0, 4'd0, 1'b1, 1'b0, 4'd0, 1'b0, 8'b1000_0000, 8'hFF, "e_beat1", o);
    step(1'b0, 4'd0, 1'b1, 1'b0, 4'd0, 1'b0, 8'b1000_0000, 8'hFF, "e_beat2", o);
    drive_idle();
    rst = 1'b1;
    #1;
    check8("e_rst_imm", obs_now(), 8'h00, 8'hFF);
    @(posedge clk);
    #1;
    rst = 1'b0;
    sb_clear();
    for (int k = 0; k < 6; k++) begin
      step(1'b0, 4'd0, 1'b0, 1'b0, 4'd0, 1'b0, 8'h00, 8'hFF, "e_after", o);
    end

    // Full channel: push with final-beat grant -> push dropped, pop happens
    step(1'b1, 4'd1, 1'b0, 1'b0, 4'd0, 1'b0, 8'b1000_0000, 8'hFF, "f_fill", o);
    step(1'b1, 4'd1, 1'b0, 1'b0, 4'd0, 1'b0, 8'b1000_0000, 8'hFF, "f_fill", o);
    step(1'b1, 4'd1, 1'b0, 1'b0, 4'd0, 1'b0, 8'b1000_0000, 8'hFF, "f_fill", o);
    step(1'b1, 4'd1, 1'b0, 1'b0, 4'd0, 1'b0, 8'b1010_0000, 8'hFF, "f_full", o);
    step(1'b1, 4'd1, 1'b1, 1'b0, 4'd0, 1'b0, 8'b1000_1010, 8'hFF, "f_push_pop", o);
    step(1'b0, 4'd0, 1'b1, 1'b0, 4'd0, 1'b0, 8'b1000_1010, 8'hFF, "f_drain", o);
    step(1'b0, 4'd0, 1'b1, 1'b0, 4'd0, 1'b0, 8'b1000_1010, 8'hFF, "f_drain", o);
    step(1'b0, 4'd0, 1'b1, 1'b0, 4'd0, 1'b0, 8'b0000_1010, 8'hFF, "f_last", o);

    // Non-full push concurrent with pop, then back-to-back burst
    step(1'b1, 4'd1, 1'b0, 1'b0, 4'd0, 1'b0, 8'b1000_0010, 8'hFF, "g_push", o);
    step(1'b1, 4'd2, 1'b1, 1'b0, 4'd0, 1'b0, 8'b1000_1010, 8'hFF, "g_push_pop", o);
    step(1'b0, 4'd0, 1'b1, 1'b0, 4'd0, 1'b0, 8'b1000_0010, 8'hFF, "g_beat", o);
    step(1'b0, 4'd0, 1'b1, 1'b0, 4'd0, 1'b0, 8'b0000_1010, 8'hFF, "g_pop", o);
    step(1'b0, 4'd0, 1'b0, 1'b0, 4'd0, 1'b0, 8'b0000_0010, 8'hFF, "g_idle", o);

    check_int("sb_empty", q1.size() + q2.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end
endmodule

// File: doc/arb_req_queue.md
Name: arb_req_queue

Overview:
- Upstream request stage for the two-requester arbiter.
- Two independent channels each accept burst commands (push + beat count) into a small per-channel FIFO.
- Each channel drives a registered request line to the arbiter and holds it until the head burst has received its full number of grant beats.
- Completes each burst with a done pulse and records protocol errors in sticky flags.

Parameters:
DEPTH, 4, entries per channel FIFO; power of 2, >= 2
LEN_W, 4, width of burst length field; lengths 1..2^LEN_W-1

Ports:
clk  input  1  clock, all state on rising edge
rst  input  1  asynchronous active-high reset
push1  input  1  enqueue a burst command on channel 1
len1  input  LEN_W  beat count for push1
push2  input  1  enqueue a burst command on channel 2
len2  input  LEN_W  beat count for push2
gnt1  input  1  grant from arbiter for channel 1, one beat per cycle high
gnt2  input  1  grant from arbiter for channel 2
req1  output  1  request to arbiter, channel 1
req2  output  1  request to arbiter, channel 2
full1  output  1  channel 1 FIFO holds DEPTH entries
full2  output  1  channel 2 FIFO holds DEPTH entries
done1  output  1  one-cycle pulse: channel 1 burst completed
done2  output  1  one-cycle pulse: channel 2 burst completed
err1  output  1  sticky error, channel 1
err2  output  1  sticky error, channel 2

Behaviour:
Reset:
- rst high clears FIFO pointers, counts, served counters, done and err for both channels.
- All outputs are 0 during and after reset until stimulus arrives.
- Reset asserted mid-burst discards all queued and partially served bursts; no done pulse is produced.

Channel operation (identical per channel n; channels never interact):
- Per-channel state: count (clog2(DEPTH)+1 bits), wr/rd pointers, served counter (LEN_W bits).
- reqn = (count != 0). It is derived from registers only; there is no combinational path from any input to reqn. This is required because the arbiter computes grants combinationally from req.
- fulln = (count == DEPTH), taken from registered count.

Push:
- pushn=1, lenn!=0, fulln=0: entry written at wr pointer, wr pointer increments modulo DEPTH, count increments.
- Latency: push into an empty channel raises reqn on the following cycle.
- Push with fulln=1 is dropped and sets errn, even if a pop occurs in the same cycle.
- Push with lenn=0 is dropped and sets errn.

Grant consumption:
- A beat is served in any cycle with gntn=1 and reqn=1; served increments.
- When served+1 == head length: entry popped, rd pointer advances, served clears to 0, and donen pulses high for exactly the next cycle.
- When the last burst pops, reqn falls on the next cycle.
- gntn=1 while reqn=0 is a spurious grant: it is ignored for data and sets errn.
- Simultaneous accepted push and pop: count unchanged, both pointers advance. A length-1 burst at the head pops in a single granted cycle.
- Back-to-back bursts: reqn stays high across a pop when count > 1. The next burst begins counting on the cycle after the pop.

Error flags:
- errn, once set, stays 1 until rst. No other clear path exists.

Test Plan:
- Reset, then push1 len1=3 at cycle 0; arbiter grants every cycle -> req1 high cycles 1-3, done1 high cycle 4, req1 low cycle 4, err1=0.
- Push1 four bursts len=1, no grants -> full1=1 after the fourth; fifth push dropped -> err1=1, count stays 4; then grant 4 cycles -> 4 done1 pulses, req1 low afterwards.
- Both channels pushed len=2 simultaneously with the arbiter attached -> all 4 beats granted, never gnt1&gnt2, done1 and done2 each pulse once, no err.
- push2 with len2=0 -> entry not queued, req2 stays 0, err2=1; gnt2 forced high while req2=0 -> err2 remains 1, no done2.
- Push1 len=5, grant 2 beats, assert rst for 1 cycle -> req1/full1/done1/err1 all 0 immediately; after rst falls, req1 stays 0 and no done1 ever appears.
- Full channel with simultaneous push and final-beat grant -> push dropped, err1=1, pop occurs, count becomes DEPTH-1.
